data_mem_stall: RTL and testbench

DATA_MEM_STALL -- requirements
Module: data_mem_stall

---
 rtl/data_mem_stall.sv | 122 ++++++++++++
 tb/tb_data_mem_stall.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_stall.sv
// Multi-cycle data memory for the MEM stage: fixed LATENCY, stall until ready.
// Define DATA_MEM_BYTE_ACCESS_EN to compile in byte loads/stores (size=1).
module data_mem_stall #(
   parameter int          WORDLENGTH = 32,
   parameter int          DEPTH      = 64,
   parameter int          LATENCY    = 4,
   parameter logic [31:0] BASE_ADDR  = 32'd1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  wr_en,
   input  logic                  size,
   input  logic [31:0]           addr,
   input  logic [WORDLENGTH-1:0] wr_data,
   output logic [WORDLENGTH-1:0] rd_data,
   output logic                  ready,
   output logic                  stall,
   output logic                  fault
);
   localparam int SH = $clog2(WORDLENGTH/8);
   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t                  state, state_nx;
   logic [3:0]              cnt;
   logic [31:0]             addr_q;
   logic                    wr_q;
   logic [WORDLENGTH-1:0]   wd_q;
   logic                    fault_q;
   logic [WORDLENGTH-1:0]   mem [DEPTH];

   logic [31:0]             off;
   logic [SH-1:0]           lane;
   logic [IW-1:0]           idx;
   logic                    byte_op, bad, accept, access;

`ifdef DATA_MEM_BYTE_ACCESS_EN
   logic size_q;
   assign byte_op = size_q;
`else
   logic unused_size;
   assign unused_size = size;
   assign byte_op     = 1'b0;
`endif

   // Decode works on the captured request so addr may change while waiting.
   assign off  = addr_q - BASE_ADDR;
   assign lane = addr_q[SH-1:0];
   assign idx  = off[IW+SH-1:SH];
   assign bad  = (addr_q < BASE_ADDR) || (|off[31:IW+SH]) || (!byte_op && lane != '0);

   assign accept = (state == IDLE) && req;
   assign access = (state == WAIT) && (cnt == 4'd0);
   assign ready  = (state == DONE);
   assign fault  = ready && fault_q;
   assign stall  = req && !ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req) state_nx = WAIT;
         WAIT:    if (cnt == 4'd0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wd_q    <= '0;
         fault_q <= 1'b0;
         rd_data <= '0;
`ifdef DATA_MEM_BYTE_ACCESS_EN
         size_q  <= 1'b0;
`endif
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (accept) begin
            cnt    <= 4'(LATENCY-1);
            addr_q <= addr;
            wr_q   <= wr_en;
            wd_q   <= wr_data;
`ifdef DATA_MEM_BYTE_ACCESS_EN
            size_q <= size;
`endif
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end

         if (access) begin
            fault_q <= bad;
            if (bad) begin
               rd_data <= '0;
            end else if (wr_q) begin
`ifdef DATA_MEM_BYTE_ACCESS_EN
               if (byte_op) mem[idx][{lane, 3'b000} +: 8] <= wd_q[7:0];
               else         mem[idx] <= wd_q;
`else
               mem[idx] <= wd_q;
`endif
            end else begin
`ifdef DATA_MEM_BYTE_ACCESS_EN
               if (byte_op) rd_data <= WORDLENGTH'(mem[idx][{lane, 3'b000} +: 8]);
               else         rd_data <= mem[idx];
`else
               rd_data <= mem[idx];
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_data_mem_stall.sv
// Scoreboard bench for data_mem_stall at default parameters (32-bit, 64 words, LATENCY 4).
module tb_data_mem_stall;
   localparam int LAT = 4;
`ifdef DATA_MEM_BYTE_ACCESS_EN
   localparam bit BYTE_EN = 1'b1;
`else
   localparam bit BYTE_EN = 1'b0;
`endif

   typedef struct packed {
      logic        fault;
      logic [31:0] rd;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b1, req = 1'b0, wr_en = 1'b0, size = 1'b0;
   logic [31:0] addr = '0, wr_data = '0;
   logic [31:0] rd_data;
   logic        ready, stall, fault;

   exp_t        sb[$];
   logic [31:0] model [64];
   logic [31:0] last_rd = '0;
   int          passed = 0, total = 0;

   always #5 clk = ~clk;

   data_mem_stall #(.WORDLENGTH(32), .DEPTH(64), .LATENCY(LAT), .BASE_ADDR(32'd1024)) dut (
      .clk(clk), .rst(rst), .req(req), .wr_en(wr_en), .size(size), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .stall(stall), .fault(fault)
   );

   // Reference behaviour of one access; pushes the expected completion.
   task automatic model_step(input logic w, input logic s, input logic [31:0] a, input logic [31:0] d);
      logic        bad, sz;
      logic [31:0] off;
      int          idx, sh;
      sz  = BYTE_EN && s;
      off = a - 32'd1024;
      bad = (a < 32'd1024) || (off[31:2] >= 30'd64) || (!sz && a[1:0] != 2'd0);
      idx = int'(off[7:2]);
      sh  = int'(a[1:0]) * 8;
      if (bad) last_rd = '0;
      else if (w) begin
         if (sz) model[idx][sh +: 8] = d[7:0];
         else    model[idx] = d;
      end else begin
         last_rd = sz ? {24'd0, model[idx][sh +: 8]} : model[idx];
      end
      sb.push_back('{bad, last_rd});
   endtask

   task automatic run_access(input logic w, input logic s, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   n;
      bit   stall_ok;
      model_step(w, s, a, d);
      @(negedge clk);
      req = 1'b1; wr_en = w; size = s; addr = a; wr_data = d;
      n = 0; stall_ok = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
         if (!ready && !stall) stall_ok = 1'b0;
      end while (!ready && n < 40);
      req = 1'b0;
      e = sb.pop_front();
      total++;
      if (n !== LAT+1) $display("FAIL latency addr=%h: ready after %0d edges, expected %0d", a, n, LAT+1);
      else passed++;
      total++;
      if (!stall_ok) $display("FAIL stall addr=%h: stall low while waiting, expected high", a);
      else passed++;
      total++;
      if (fault !== e.fault) $display("FAIL fault addr=%h: got %b expected %b", a, fault, e.fault);
      else passed++;
      total++;
      if (rd_data !== e.rd) $display("FAIL rd_data addr=%h: got %h expected %h", a, rd_data, e.rd);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (ready !== 1'b0) $display("FAIL ready_width addr=%h: got %b expected 0", a, ready);
      else passed++;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 64; i++) model[i] = '0;
      rst = 1'b1;
      #12;
      total++;
      if ({ready, fault, stall} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {ready, fault, stall});
      else passed++;
      total++;
      if (rd_data !== 32'd0) $display("FAIL reset_rd_data: got %h expected 0", rd_data);
      else passed++;
      @(negedge clk); rst = 1'b0;
      run_access(1'b0, 1'b0, 32'd1028, 32'd0);
   endtask

   task automatic test_word;
      run_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
      run_access(1'b0, 1'b0, 32'd1028, 32'd0);
      run_access(1'b1, 1'b0, 32'd1276, 32'h0BADF00D);
      run_access(1'b0, 1'b0, 32'd1276, 32'd0);
      run_access(1'b0, 1'b0, 32'd1024, 32'd0);
   endtask

   task automatic test_byte;
      run_access(1'b1, 1'b0, 32'd1028, 32'h11223344);
      run_access(1'b1, 1'b1, 32'd1030, 32'hFFFFFF5A);
      run_access(1'b0, 1'b0, 32'd1028, 32'd0);
      run_access(1'b0, 1'b1, 32'd1030, 32'd0);
      run_access(1'b0, 1'b1, 32'd1031, 32'd0);
   endtask

   task automatic test_fault;
      run_access(1'b0, 1'b0, 32'd1020, 32'd0);
      run_access(1'b0, 1'b0, 32'd1280, 32'd0);
      run_access(1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0);
      run_access(1'b0, 1'b0, 32'd0, 32'd0);
      run_access(1'b0, 1'b0, 32'd1025, 32'd0);
      run_access(1'b1, 1'b0, 32'd1026, 32'h12345678);
      run_access(1'b1, 1'b0, 32'd1020, 32'h87654321);
      run_access(1'b0, 1'b0, 32'd1024, 32'd0);
      run_access(1'b0, 1'b0, 32'd1028, 32'd0);
   endtask

   task automatic test_reset_abort;
      int pulses;
      @(negedge clk);
      req = 1'b1; wr_en = 1'b1; size = 1'b0; addr = 32'd1032; wr_data = 32'hCAFEF00D;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1; req = 1'b0;
      #1;
      total++;
      if ({ready, fault} !== 2'b00) $display("FAIL abort_flags: got %b expected 00", {ready, fault});
      else passed++;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 64; i++) model[i] = '0;
      last_rd = '0;
      pulses = 0;
      repeat (LAT+3) begin
         @(posedge clk); #1;
         if (ready) pulses++;
      end
      total++;
      if (pulses !== 0) $display("FAIL abort_ready: got %0d pulses expected 0", pulses);
      else passed++;
      run_access(1'b0, 1'b0, 32'd1032, 32'd0);
      run_access(1'b0, 1'b0, 32'd1028, 32'd0);
      run_access(1'b1, 1'b0, 32'd1032, 32'h00C0FFEE);
      run_access(1'b0, 1'b0, 32'd1032, 32'd0);
   endtask

   task automatic test_back_to_back;
      int   pulses;
      exp_t e;
      model_step(1'b1, 1'b0, 32'd1036, 32'hA5A5A5A5);
      @(negedge clk);
      req = 1'b1; wr_en = 1'b1; size = 1'b0; addr = 32'd1036; wr_data = 32'hA5A5A5A5;
      pulses = 0;
      repeat (3*(LAT+2)+4) begin
         @(posedge clk); #1;
         if (ready) begin
            pulses++;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               total++;
               if (fault !== e.fault) $display("FAIL b2b_fault pulse %0d: got %b expected %b", pulses, fault, e.fault);
               else passed++;
            end
            if (pulses == 1) begin
               addr = 32'd1040; wr_data = 32'h5A5A5A5A;
               model_step(1'b1, 1'b0, 32'd1040, 32'h5A5A5A5A);
            end else begin
               req = 1'b0;
            end
         end
      end
      req = 1'b0;
      sb.delete();
      total++;
      if (pulses !== 2) $display("FAIL b2b_pulses: got %0d expected 2", pulses);
      else passed++;
      run_access(1'b0, 1'b0, 32'd1036, 32'd0);
      run_access(1'b0, 1'b0, 32'd1040, 32'd0);
   endtask

   initial begin
      test_reset;
      test_word;
      test_byte;
      test_fault;
      test_reset_abort;
      test_back_to_back;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
